// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-channel state encoding for the SRAM slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam int         ID_W_DEFAULT = 4;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

endpackage

// File: rtl/sram_bytewrite.sv
// Word-wide RAM with one byte-enabled write port and one registered read port.
// The read register holds its value until the next read enable, or is cleared by rd_clr.
module sram_bytewrite #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Non-blocking read of the array returns pre-write data on a same-edge collision.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave in front of a byte-writable SRAM; read and write channels run independently.
// Define AXI_SRAM_OOR_ERR_EN to answer out-of-range addresses with SLVERR instead of wrapping.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int ID_W  = ID_W_DEFAULT
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic [1:0]      awlock,
    input  logic [3:0]      awcache,
    input  logic [2:0]      awprot,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic [1:0]      arlock,
    input  logic [3:0]      arcache,
    input  logic [2:0]      arprot,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);

    localparam int IDX_W = $clog2(DEPTH);

    r_state_t        r_state_reg, r_state_next;
    logic            ready_en_reg;
    logic [ID_W-1:0] rid_reg;
    logic [1:0]      rresp_reg;

    logic            aw_held_reg, w_held_reg;
    logic [ID_W-1:0] awid_reg;
    logic [IDX_W-1:0] aw_idx_reg;
    logic            aw_oor_reg;
    logic [31:0]     wdata_reg;
    logic [3:0]      wstrb_reg;
    logic            bvalid_reg;
    logic [ID_W-1:0] bid_reg;
    logic [1:0]      bresp_reg;

    logic            ar_hs, aw_hs, w_hs;
    logic            ar_oor, aw_oor;
    logic            wr_fire, wr_oor, mem_we, rd_en, rd_clr;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]     wr_data;
    logic [3:0]      wr_strb;
    logic [ID_W-1:0] wr_id;

`ifdef AXI_SRAM_OOR_ERR_EN
    assign ar_oor = |araddr[31:IDX_W+2];
    assign aw_oor = |awaddr[31:IDX_W+2];
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
`endif

    // Read channel FSM; readies stay low until the first edge out of reset.
    always_comb begin
        r_state_next = r_state_reg;
        arready      = 1'b0;
        rvalid       = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                arready = ready_en_reg;
                if (arvalid && ready_en_reg) begin
                    r_state_next = R_RESP;
                end
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    r_state_next = R_IDLE;
                end
            end
        endcase
    end

    assign ar_hs  = arvalid && arready;
    assign rd_en  = ar_hs && aresetn;
    assign rd_clr = !aresetn || (ar_hs && ar_oor);
    assign rlast  = rvalid;
    assign rid    = rid_reg;
    assign rresp  = rresp_reg;

    // AW and W are collected independently; the write fires on the edge the second one lands.
    assign awready = ready_en_reg && !aw_held_reg && !bvalid_reg;
    assign wready  = ready_en_reg && !w_held_reg && !bvalid_reg;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign wr_fire = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    assign wr_idx  = aw_held_reg ? aw_idx_reg : awaddr[IDX_W+1:2];
    assign wr_id   = aw_held_reg ? awid_reg : awid;
    assign wr_oor  = aw_held_reg ? aw_oor_reg : aw_oor;
    assign wr_data = w_held_reg ? wdata_reg : wdata;
    assign wr_strb = w_held_reg ? wstrb_reg : wstrb;
    assign mem_we  = wr_fire && aresetn && !wr_oor;

    assign bvalid = bvalid_reg;
    assign bid    = bid_reg;
    assign bresp  = bresp_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_reg  <= R_IDLE;
            ready_en_reg <= 1'b0;
            rid_reg      <= '0;
            rresp_reg    <= RESP_OKAY;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bid_reg      <= '0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            r_state_reg  <= r_state_next;
            ready_en_reg <= 1'b1;
            if (ar_hs) begin
                rid_reg   <= arid;
                rresp_reg <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            end
            if (wr_fire) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bid_reg     <= wr_id;
                bresp_reg   <= wr_oor ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                end
                if (bvalid_reg && bready) begin
                    bvalid_reg <= 1'b0;
                end
            end
        end
    end

    // Held request payloads need no reset: they are only used while a held flag is set.
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            awid_reg   <= awid;
            aw_idx_reg <= awaddr[IDX_W+1:2];
            aw_oor_reg <= aw_oor;
        end
        if (w_hs) begin
            wdata_reg <= wdata;
            wstrb_reg <= wstrb;
        end
    end

    sram_bytewrite #(
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_sram (
        .clk     (aclk),
        .rd_clr  (rd_clr),
        .rd_en   (rd_en),
        .rd_addr (araddr[IDX_W+1:2]),
        .rd_data (rdata),
        .wr_en   (mem_we),
        .wr_addr (wr_idx),
        .wr_be   (wr_strb),
        .wr_data (wr_data)
    );

    logic unused_inputs;
    assign unused_inputs = ^{awlen, awsize, awburst, awlock, awcache, awprot, wid, wlast,
                             arlen, arsize, arburst, arlock, arcache, arprot, awaddr, araddr};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized scoreboard bench for axi_sram_slave against a word-array reference model.
`timescale 1ns/1ps
module tb_axi_sram_slave;

    localparam int DEPTH = 1024;
    localparam int ID_W  = 4;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [ID_W-1:0] awid = '0, wid = '0, arid = '0;
    logic [31:0]     awaddr = '0, araddr = '0, wdata = '0;
    logic [7:0]      awlen = '0, arlen = '0;
    logic [2:0]      awsize = '0, arsize = '0, awprot = '0, arprot = '0;
    logic [1:0]      awburst = '0, arburst = '0, awlock = '0, arlock = '0;
    logic [3:0]      awcache = '0, arcache = '0, wstrb = '0;
    logic            awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b1, arvalid = 1'b0;
    logic            bready = 1'b0, rready = 1'b0;
    logic            awready, wready, arready, bvalid, rvalid, rlast;
    logic [ID_W-1:0] bid, rid;
    logic [1:0]      bresp, rresp;
    logic [31:0]     rdata;

    axi_sram_slave #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [ID_W-1:0] id; logic [31:0] data; logic [1:0] resp; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] model [DEPTH];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
`ifdef AXI_SRAM_OOR_ERR_EN
        return a >= 32'(DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic r_exp_t read_expect(input logic [ID_W-1:0] id, input logic [31:0] a);
        r_exp_t e;
        e.id   = id;
        e.data = is_oor(a) ? 32'h0 : model[widx(a)];
        e.resp = is_oor(a) ? 2'b10 : 2'b00;
        return e;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!is_oor(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[widx(a)][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    // Called with valid already high; returns at posedge+1 after the handshake edge.
    task automatic wait_hs(input int sel, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!rdy(sel) && n < 50);
        if (!rdy(sel)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: handshake timeout, ready got 0 expected 1", nm);
        end
        @(posedge aclk); #1;
    endtask

    task automatic write_issue(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int aw_d, input int w_d, output b_exp_t e);
        fork
            begin
                repeat (aw_d) begin @(posedge aclk); #1; end
                awid = id; awaddr = a; awvalid = 1'b1;
                wait_hs(0, "aw_hs");
                awvalid = 1'b0;
            end
            begin
                repeat (w_d) begin @(posedge aclk); #1; end
                wdata = d; wstrb = s; wvalid = 1'b1;
                wait_hs(1, "w_hs");
                wvalid = 1'b0;
            end
        join
        chk("bvalid_latency", bvalid, 1);
        e.id   = id;
        e.resp = is_oor(a) ? 2'b10 : 2'b00;
        bq.push_back(e);
        model_write(a, d, s);
    endtask

    task automatic write_resp(input b_exp_t e, input int b_d);
        repeat (b_d) begin
            @(negedge aclk);
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_id", bid, e.id);
            chk("b_hold_awready", {awready, wready}, 2'b00);
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
    endtask

    task automatic write_txn(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_d, input int w_d, input int b_d);
        b_exp_t e;
        write_issue(id, a, d, s, aw_d, w_d, e);
        write_resp(e, b_d);
    endtask

    task automatic read_txn(input logic [ID_W-1:0] id, input logic [31:0] a, input int r_d);
        r_exp_t e;
        e = read_expect(id, a);
        arid = id; araddr = a; arvalid = 1'b1;
        wait_hs(2, "ar_hs");
        arvalid = 1'b0;
        chk("rvalid_latency", {rvalid, rlast, arready}, 3'b110);
        rq.push_back(e);
        repeat (r_d) begin
            @(negedge aclk);
            chk("r_hold_valid", {rvalid, arready}, 2'b10);
            chk("r_hold_data", rdata, e.data);
            chk("r_hold_id", rid, e.id);
            @(posedge aclk); #1;
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        chk("r_done", {rvalid, arready}, 2'b01);
    endtask

    task automatic pulse_reset();
        bq.delete();
        rq.delete();
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk("rst_valids", {bvalid, rvalid, rlast}, 3'b000);
        chk("rst_readies", {arready, awready, wready}, 3'b000);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_readies_pre_edge", {arready, awready, wready}, 3'b000);
        @(posedge aclk); #1;
        chk("rst_readies_release", {arready, awready, wready}, 3'b111);
    endtask

    // Scoreboard monitors: pop an expectation whenever a response handshake is about to occur.
    always @(negedge aclk) begin
        b_exp_t be;
        if (aresetn && bvalid && bready) begin
            if (bq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected: got response id %0h expected none", bid);
            end else begin
                be = bq.pop_front();
                chk("bid", bid, be.id);
                chk("bresp", bresp, be.resp);
            end
        end
    end

    always @(negedge aclk) begin
        r_exp_t re;
        if (aresetn && rvalid && rready) begin
            if (rq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL r_unexpected: got response id %0h expected none", rid);
            end else begin
                re = rq.pop_front();
                chk("rid", rid, re.id);
                chk("rdata", rdata, re.data);
                chk("rresp", rresp, re.resp);
                chk("rlast", rlast, 1);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a1, a2, d;
        logic [3:0]  s;
        int          op;
        b_exp_t      be;

        repeat (3) begin @(posedge aclk); #1; end
        chk("reset_outputs", {arready, awready, wready, rvalid, bvalid, rlast}, 6'b0);
        chk("reset_ids", {rid, bid, rresp, bresp}, 12'h0);
        chk("reset_rdata", rdata, 32'h0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("first_edge_readies", {arready, awready, wready}, 3'b111);

        for (int i = 0; i < 32; i++) write_txn(4'(i), 32'(i * 4), $urandom, 4'hF, 0, 0, 0);

        write_txn(4'd3, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        read_txn(4'd5, 32'h10, 0);
        write_txn(4'd2, 32'h10, 32'h0000AB00, 4'b0010, 2, 0, 1);
        read_txn(4'd1, 32'h10, 5);

        write_txn(4'd6, 32'h20, 32'h11111111, 4'hF, 1, 0, 0);
        fork
            read_txn(4'd6, 32'h20, 0);
            write_txn(4'd7, 32'h20, 32'h22222222, 4'hF, 0, 0, 0);
        join
        read_txn(4'd8, 32'h20, 0);

        write_txn(4'd9, 32'h40, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        write_issue(4'd10, 32'h40, 32'h12345678, 4'hF, 0, 0, be);
        pulse_reset();
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        wait_hs(1, "w_only_hs");
        wvalid = 1'b0;
        pulse_reset();
        awid = 4'd11; awaddr = 32'h40; awvalid = 1'b1;
        wait_hs(0, "aw_only_hs");
        awvalid = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            chk("no_write_after_reset", bvalid, 0);
        end
        pulse_reset();
        read_txn(4'd12, 32'h40, 0);
        write_txn(4'd13, 32'h44, 32'h5A5A5A5A, 4'h0, 1, 0, 0);
        read_txn(4'd13, 32'h44, 0);

        write_txn(4'd4, 32'h1000, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        read_txn(4'd4, 32'h1000, 0);
        read_txn(4'd5, 32'h0, 0);

        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 2));
            a1 = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a1 = a1 + 32'($urandom_range(1, 3) * 32'h1000);
            a2 = ($urandom_range(0, 1) == 0) ? a1 : 32'($urandom_range(0, 31) * 4);
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            case (op)
                0: write_txn(4'($urandom), a1, d, s, int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
                1: read_txn(4'($urandom), a2, int'($urandom_range(0, 3)));
                default: fork
                    read_txn(4'($urandom), a2, 0);
                    write_txn(4'($urandom), a1, d, s, 0, 0, int'($urandom_range(0, 3)));
                join
            endcase
        end

        repeat (3) begin @(posedge aclk); #1; end
        chk("b_queue_drained", 32'(bq.size()), 0);
        chk("r_queue_drained", 32'(rq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
